// File: rtl/tinytone_pkg.sv
// -----------------------------------------------------------------------------
// tinytone_pkg
// Shared constants for the TinyTone sound path.
//   - Default envelope level / step-period widths.
//   - Envelope FSM state encodings (3-bit).
// No ports; import with "import tinytone_pkg::*;".
// -----------------------------------------------------------------------------
package tinytone_pkg;

   // Default widths for the envelope stage.
   localparam int unsigned LvlBwDef  = 4;
   localparam int unsigned StepBwDef = 16;

   // Envelope FSM state encodings.
   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StAttack  = 3'd1;
   localparam logic [2:0] StDecay   = 3'd2;
   localparam logic [2:0] StSustain = 3'd3;
   localparam logic [2:0] StRelease = 3'd4;

endpackage

// File: rtl/env_step_timer.sv
// -----------------------------------------------------------------------------
// env_step_timer
// Step-period timer for the envelope FSM. Counts clocks while enabled and
// raises a one-cycle expiry pulse when cnt+1 >= step_i, then restarts from 0.
// Step values 0 and 1 both expire every enabled clock. The period is sampled
// live, so lowering it mid-step expires on the next enabled cycle. The counter
// saturates at all-ones instead of wrapping.
//
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   clr_i     synchronous clear (has priority over counting)
//   en_i      count enable
//   step_i    step period in clocks
//   expire_o  combinational expiry pulse for the current cycle
// -----------------------------------------------------------------------------
module env_step_timer
   import tinytone_pkg::*;
#(
   parameter int unsigned STEP_BW = StepBwDef
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [STEP_BW-1:0] step_i,
   output logic               expire_o
);

   logic [STEP_BW-1:0] cnt_q, cnt_d;
   logic [STEP_BW:0]   cnt_inc;

   // One extra bit so the compare is correct when cnt_q is saturated.
   assign cnt_inc  = {1'b0, cnt_q} + {{STEP_BW{1'b0}}, 1'b1};
   assign expire_o = en_i & (cnt_inc >= {1'b0, step_i});

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (expire_o) begin
            cnt_d = '0;
         end else if (cnt_q != {STEP_BW{1'b1}}) begin
            cnt_d = cnt_inc[STEP_BW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/envelope_shaper.sv
// -----------------------------------------------------------------------------
// envelope_shaper
// ADSR amplitude-envelope stage for the TinyTone sound path. The raw square
// tone is gated by a high-rate amplitude PWM whose duty follows the envelope
// level, removing note-boundary clicks and giving notes shape.
//
// Build option:
//   TINYTONE_ENV_RETRIG_EN  defined   -> trig_i re-enters ATTACK from DECAY,
//                                        SUSTAIN and RELEASE (level kept).
//                           undefined -> trig_i honoured only in IDLE and
//                                        RELEASE.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous active-high reset
//   tone_i          square-wave tone from the PWM modulator
//   gate_i          note held (1) / note off (0)
//   trig_i          one-cycle note-start strobe, qualified by gate_i
//   attack_step_i   clocks per +1 level step in ATTACK
//   decay_step_i    clocks per -1 level step in DECAY
//   release_step_i  clocks per -1 level step in RELEASE
//   sustain_lvl_i   SUSTAIN target level
//   sound_o         registered shaped audio output
//   level_o         current envelope level
//   busy_o          high in every state except IDLE
// -----------------------------------------------------------------------------
module envelope_shaper
   import tinytone_pkg::*;
#(
   parameter int unsigned LVL_BW  = LvlBwDef,
   parameter int unsigned STEP_BW = StepBwDef
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               tone_i,
   input  logic               gate_i,
   input  logic               trig_i,
   input  logic [STEP_BW-1:0] attack_step_i,
   input  logic [STEP_BW-1:0] decay_step_i,
   input  logic [STEP_BW-1:0] release_step_i,
   input  logic [LVL_BW-1:0]  sustain_lvl_i,
   output logic               sound_o,
   output logic [LVL_BW-1:0]  level_o,
   output logic               busy_o
);

   localparam logic [LVL_BW-1:0] LvlMax = {LVL_BW{1'b1}};
   localparam logic [LVL_BW-1:0] LvlOne = {{(LVL_BW-1){1'b0}}, 1'b1};

   logic [2:0]         state_q, state_d;
   logic [LVL_BW-1:0]  level_q, level_d;
   logic [LVL_BW-1:0]  frame_q;
   logic               sound_q;

   logic               trig_ok;
   logic               retrig_ok;
   logic               step_en;
   logic               step_clr;
   logic               step_exp;
   logic [STEP_BW-1:0] step_sel;

   // A trigger only counts while the note is held; a falling gate wins.
   assign trig_ok = trig_i & gate_i;

`ifdef TINYTONE_ENV_RETRIG_EN
   assign retrig_ok = trig_ok;
`else
   assign retrig_ok = 1'b0;
`endif

   // Step timer control: runs in the ramping states, restarts on any change.
   always_comb begin
      step_en  = 1'b0;
      step_sel = attack_step_i;
      case (state_q)
         StAttack: begin
            step_en  = 1'b1;
            step_sel = attack_step_i;
         end
         StDecay: begin
            step_en  = 1'b1;
            step_sel = decay_step_i;
         end
         StRelease: begin
            step_en  = 1'b1;
            step_sel = release_step_i;
         end
         default: begin
            step_en  = 1'b0;
            step_sel = attack_step_i;
         end
      endcase
   end

   assign step_clr = (state_d != state_q);

   env_step_timer #(
      .STEP_BW (STEP_BW)
   ) u_step_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (step_clr),
      .en_i     (step_en),
      .step_i   (step_sel),
      .expire_o (step_exp)
   );

   // Envelope FSM. Any state transition keeps the level unchanged on that edge,
   // so a retrigger continues from the current level without a click.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      case (state_q)
         StIdle: begin
            if (trig_ok) begin
               state_d = StAttack;
            end
         end
         StAttack: begin
            if (!gate_i) begin
               state_d = StRelease;
            end else if (level_q == LvlMax) begin
               state_d = StDecay;
            end else if (step_exp) begin
               level_d = level_q + LvlOne;
            end
         end
         StDecay: begin
            if (!gate_i) begin
               state_d = StRelease;
            end else if (retrig_ok) begin
               state_d = StAttack;
            end else if (level_q <= sustain_lvl_i) begin
               state_d = StSustain;
            end else if (step_exp) begin
               level_d = level_q - LvlOne;
            end
         end
         StSustain: begin
            // Level frozen here; sustain_lvl_i is not re-examined.
            if (!gate_i) begin
               state_d = StRelease;
            end else if (retrig_ok) begin
               state_d = StAttack;
            end
         end
         StRelease: begin
            if (trig_ok) begin
               state_d = StAttack;
            end else if (level_q == '0) begin
               state_d = StIdle;
            end else if (step_exp) begin
               level_d = level_q - LvlOne;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         level_q <= '0;
         frame_q <= '0;
         sound_q <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         frame_q <= frame_q + LvlOne;
         // Duty = level / 2^LVL_BW; level 0 keeps the pin silent.
         sound_q <= tone_i & (frame_q < level_q);
      end
   end

   assign sound_o = sound_q;
   assign level_o = level_q;
   assign busy_o  = (state_q != StIdle);

endmodule

// File: doc/envelope_shaper.md
# envelope_shaper

Amplitude-envelope stage placed directly downstream of the PWM tone generator in the TinyTone sound path. It takes the raw square-wave tone and a note gate/trigger from the sequencer. It drives the output pin with the tone gated by a high-rate amplitude PWM whose level follows an attack/decay/sustain/release envelope. This removes note-boundary clicks and gives notes shape.

## Interface
- `LVL_BW`, default 4: envelope level width; maximum level is LVL_MAX = 2^LVL_BW−1.
- `STEP_BW`, default 16: width of the step-period inputs and the step counter.
- `clk_i`, input, 1: single system clock.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `tone_i`, input, 1: square-wave tone from the PWM modulator.
- `gate_i`, input, 1: note held (1) / note off or rest (0); level signal.
- `trig_i`, input, 1: one-cycle note-start strobe; effective only while gate_i=1.
- `attack_step_i`, input, STEP_BW: clocks per +1 level step in ATTACK.
- `decay_step_i`, input, STEP_BW: clocks per −1 level step in DECAY.
- `release_step_i`, input, STEP_BW: clocks per −1 level step in RELEASE.
- `sustain_lvl_i`, input, LVL_BW: SUSTAIN target level.
- `sound_o`, output, 1: shaped audio output to the pin.
- `level_o`, output, LVL_BW: current envelope level.
- `busy_o`, output, 1: high in every state except IDLE.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- IDLE → ATTACK on trig_i & gate_i. Level starts from its current value.
- ATTACK: level +1 per step expiry. At level LVL_MAX → DECAY.
- DECAY: level −1 per step expiry while level > sustain_lvl_i. Level ≤ sustain_lvl_i → SUSTAIN on the next cycle, with no step wait.
- SUSTAIN: level held. Later changes to sustain_lvl_i are ignored until the next ATTACK.
- Any of ATTACK/DECAY/SUSTAIN with gate_i=0 → RELEASE.
- RELEASE: level −1 per step expiry. At level 0 → IDLE.
- Retrigger: trig_i & gate_i in DECAY, SUSTAIN or RELEASE → ATTACK. Level is kept, so there is no click.
- Simultaneous trig_i and gate_i falling: gate_i=0 wins, so trig is ignored.
- Step timer: cleared on every state change. It counts up each cycle in ATTACK/DECAY/RELEASE.
  - Expiry when step_cnt+1 ≥ current step input; step_cnt then clears.
  - Step values 0 and 1 both mean one level step per clock.
  - Step inputs are sampled live; lowering one mid-step expires on the next cycle.
  - The timer saturates; it never wraps.
- Amplitude PWM: a free-running LVL_BW-bit frame counter, 0..LVL_MAX, wrapping.
- sound_o = tone_i & (frame_cnt < level).
  - Level 0 → constant 0.
  - LVL_MAX → high for LVL_MAX of every 2^LVL_BW clocks while tone_i=1.

## Timing
- Reset values: state IDLE, level_o 0, busy_o 0, sound_o 0, step_cnt 0, frame_cnt 0.
- State, level and step counter all update on the clock edge. trig_i at cycle n → state ATTACK, busy_o=1 at n+1.
- sound_o is registered: tone_i at cycle n appears at n+1, using the level and frame_cnt of cycle n.
- A level change at expiry edge n is visible on level_o at n+1.
- rst_i mid-note forces all reset values on the next edge, overriding every other input.

## Configuration
- `TINYTONE_ENV_RETRIG_EN` defined: retrigger is honoured in DECAY, SUSTAIN and RELEASE, as described above.
- Undefined: trig_i is honoured only in IDLE and RELEASE; it is ignored in ATTACK, DECAY and SUSTAIN.

## Structure
- Shared package `tinytone_pkg`: state encodings (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4, 3-bit) and default LVL_BW/STEP_BW constants.
- One sub-module: `env_step_timer`. It takes a clear input, an enable input and the step period, and produces a one-cycle expiry pulse.

## Test plan
All scenarios use LVL_BW=4.
- Reset, then tone_i toggling with gate_i=0 → sound_o stays 0, level_o 0, busy_o 0.
- attack=4, decay=2, sustain=8, trig at cycle 0 → level_o 15 at about cycle 61; DECAY reaches 8 14 cycles later; then SUSTAIN holds 8.
- gate_i falls in SUSTAIN at level 8, release=3 → level_o 0 about 24 cycles later, then IDLE with busy_o 0.
- tone_i held at 1 with level 4 → sound_o is high for exactly 4 of each 16-cycle frame.
- trig_i in RELEASE at level 5 → ATTACK from 5. The same trig in SUSTAIN is ignored when TINYTONE_ENV_RETRIG_EN is undefined.
- trig_i with gate_i falling in the same cycle → RELEASE. rst_i asserted in ATTACK → all outputs 0 next cycle.
